// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - fetch, loader and memory-port signals of the imem arbiter
interface imem_arbiter_if #(
  parameter int AW = 10
);
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_gnt;
  logic          fetch_rvalid;
  logic [31:0]   fetch_rdata;

  logic          ld_req;
  logic          ld_we;
  logic [31:0]   ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [31:0]   ld_rdata;

  logic          err;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata,
    output ld_gnt, ld_rvalid, ld_rdata,
    output err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr,
    output ld_req, ld_we, ld_addr, ld_wdata,
    output mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - single-port instruction memory arbiter between fetch and loader
// Loader has priority; fetch is forced through after STARVE_MAX consecutive loader wins.
module imem_arbiter #(
  parameter int DEPTH      = 1024,
  parameter int AW         = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         reset,
  imem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    RSP_NONE,
    RSP_FETCH,
    RSP_LD,
    RSP_BAD_FETCH,
    RSP_BAD_LD
  } rsp_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  rsp_t       rsp_st;
  logic [3:0] starve_cnt;
  logic       fetch_bad;
  logic       ld_bad;
  logic       fetch_win;
  logic       ld_win;
  logic       win_bad;

  always_comb begin
    fetch_bad = (bus.fetch_addr[1:0] != 2'b00) || (bus.fetch_addr[31:2] >= 30'(DEPTH));
    ld_bad    = (bus.ld_addr[1:0] != 2'b00) || (bus.ld_addr[31:2] >= 30'(DEPTH));
    fetch_win = !reset && bus.fetch_req && (!bus.ld_req || (starve_cnt == STARVE_LIM));
    ld_win    = !reset && bus.ld_req && !fetch_win;
    win_bad   = (fetch_win && fetch_bad) || (ld_win && ld_bad);
  end

  assign bus.fetch_gnt = fetch_win;
  assign bus.ld_gnt    = ld_win;

  // Bad accesses are still granted but never reach the array.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (fetch_win) begin
      bus.mem_en   = !fetch_bad;
      bus.mem_addr = bus.fetch_addr[AW+1:2];
    end else if (ld_win) begin
      bus.mem_en    = !ld_bad;
      bus.mem_we    = !ld_bad && bus.ld_we;
      bus.mem_addr  = bus.ld_addr[AW+1:2];
      bus.mem_wdata = bus.ld_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_st           <= RSP_NONE;
      starve_cnt       <= 4'd0;
      bus.fetch_rvalid <= 1'b0;
      bus.ld_rvalid    <= 1'b0;
      bus.err          <= 1'b0;
    end else begin
      starve_cnt <= (ld_win && bus.fetch_req) ? starve_cnt + 4'd1 : 4'd0;
      // A bad write flags err without any read response.
      bus.err    <= win_bad;
      if (fetch_win) begin
        rsp_st           <= fetch_bad ? RSP_BAD_FETCH : RSP_FETCH;
        bus.fetch_rvalid <= 1'b1;
        bus.ld_rvalid    <= 1'b0;
      end else if (ld_win && !bus.ld_we) begin
        rsp_st           <= ld_bad ? RSP_BAD_LD : RSP_LD;
        bus.fetch_rvalid <= 1'b0;
        bus.ld_rvalid    <= 1'b1;
      end else begin
        rsp_st           <= RSP_NONE;
        bus.fetch_rvalid <= 1'b0;
        bus.ld_rvalid    <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.fetch_rdata = (rsp_st == RSP_FETCH) ? bus.mem_rdata : 32'h0;
    bus.ld_rdata    = (rsp_st == RSP_LD)    ? bus.mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - scoreboard bench for imem_arbiter against a behavioural model
`timescale 1ns/1ps
module tb_imem_arbiter;
  localparam int DEPTH      = 1024;
  localparam int AW         = 10;
  localparam int STARVE_MAX = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_arbiter_if #(.AW(AW)) bus();

  imem_arbiter #(.DEPTH(DEPTH), .AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic        fv;
    logic        lv;
    logic        er;
    logic [31:0] data;
  } exp_rsp_t;

  exp_rsp_t    q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;
  logic        loaded = 1'b0;
  logic [31:0] env_mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int          streak = 0;
  logic        last_fgnt;
  logic        last_lgnt;

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h03200513;
    if (i == 1) return 32'h01E00393;
    if (i == 2) return 32'h00A38233;
    return (32'(i) * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory array: synchronous read, write on enable.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < DEPTH; i++) env_mem[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= env_mem[bus.mem_addr];
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, wanted %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] a);
    return ((a % 4) != 0) || ((a / 4) >= DEPTH);
  endfunction

  // Monitor: pops one expected response whenever its cycle comes due.
  exp_rsp_t e;
  always @(negedge clk) begin
    if (!reset && mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL missing_rsp: wanted response at cycle %0d, none at %0d", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("rsp",
            128'({bus.fetch_rvalid, bus.ld_rvalid, bus.err, bus.fetch_rdata, bus.ld_rdata}),
            128'({e.fv, e.lv, e.er, (e.fv ? e.data : 32'h0), (e.lv ? e.data : 32'h0)}));
      end else begin
        chk("idle_rsp",
            128'({bus.fetch_rvalid, bus.ld_rvalid, bus.err, bus.fetch_rdata, bus.ld_rdata}),
            128'(0));
      end
    end
  end

  // One cycle: drive requests, compare grants and memory port against the model.
  task automatic step(input logic fr, input logic [31:0] fa,
                      input logic lr, input logic lw, input logic [31:0] la,
                      input logic [31:0] ld, output logic fg, output logic lg);
    logic          fbad, lbad, en, we;
    logic [AW-1:0] fi, li;
    bus.fetch_req  = fr;
    bus.fetch_addr = fa;
    bus.ld_req     = lr;
    bus.ld_we      = lw;
    bus.ld_addr    = la;
    bus.ld_wdata   = ld;
    @(negedge clk);
    fbad = is_bad(fa);
    lbad = is_bad(la);
    fi   = AW'(fa / 4);
    li   = AW'(la / 4);
    fg   = fr && (!lr || streak >= STARVE_MAX);
    lg   = lr && !fg;
    en   = (fg && !fbad) || (lg && !lbad);
    we   = lg && !lbad && lw;
    last_fgnt = bus.fetch_gnt;
    last_lgnt = bus.ld_gnt;
    chk("grants", 128'({bus.fetch_gnt, bus.ld_gnt}), 128'({fg, lg}));
    chk("mem_en_we", 128'({bus.mem_en, bus.mem_we}), 128'({en, we}));
    if (en) chk("mem_addr", 128'(bus.mem_addr), 128'(fg ? fi : li));
    if (we) chk("mem_wdata", 128'(bus.mem_wdata), 128'(ld));
    if (!fg && !lg) chk("mem_idle", 128'({bus.mem_addr, bus.mem_wdata}), 128'(0));
    if (fg) begin
      q.push_back('{cyc + 1, 1'b1, 1'b0, fbad, (fbad ? 32'h0 : ref_mem[fi])});
    end else if (lg) begin
      if (!lw) q.push_back('{cyc + 1, 1'b0, 1'b1, lbad, (lbad ? 32'h0 : ref_mem[li])});
      else if (lbad) q.push_back('{cyc + 1, 1'b0, 1'b0, 1'b1, 32'h0});
      else ref_mem[li] = ld;
    end
    streak = (lg && fr) ? streak + 1 : 0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
    if (r == 1) return 32'(DEPTH * 4) + ($urandom_range(0, 255) << 2);
    if (r == 2) return 32'h8000_0000 | ($urandom_range(0, 15) << 2);
    if (r == 3) return 32'((DEPTH - 1) * 4);
    return $urandom_range(0, 15) << 2;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic        fg, lg, pf, pl, lw;
    logic [31:0] fa, la, ld;
    int          diffs;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs",
        128'({bus.fetch_gnt, bus.ld_gnt, bus.fetch_rvalid, bus.ld_rvalid, bus.err, bus.mem_en,
              bus.mem_we, bus.fetch_rdata, bus.ld_rdata, bus.mem_addr, bus.mem_wdata}), 128'(0));
    reset  = 1'b0;
    mon_en = 1'b1;

    // Fetch alone, three consecutive words.
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);
    step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);
    step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);

    // Loader write then fetch of the same word.
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, fg, lg);
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);

    // Both requesting continuously: L,L,L,L,F repeating.
    fa = 32'h20;
    la = 32'h40;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, fa, 1'b1, 1'b0, la, 32'h0, fg, lg);
      chk("starve_pattern", 128'({last_fgnt, last_lgnt}), 128'((i % 5 == 4) ? 2'b10 : 2'b01));
      if (fg) fa = fa + 32'h4;
      if (lg) la = la + 32'h4;
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);

    // Misaligned fetch and out-of-range loader write.
    step(1'b1, 32'h6, 1'b1, 1'b1, 32'h1000, 32'hBAD0BAD0, fg, lg);
    step(1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);

    // Reset while a fetch response is on the bus.
    step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h4;
    bus.ld_req     = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("reset_async",
        128'({bus.fetch_gnt, bus.ld_gnt, bus.fetch_rvalid, bus.ld_rvalid, bus.err, bus.mem_en,
              bus.mem_we, bus.fetch_rdata, bus.ld_rdata, bus.mem_addr, bus.mem_wdata}), 128'(0));
    q.delete();
    streak = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);
    chk("first_grant_after_reset", 128'(last_fgnt), 128'(1));
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);

    // Randomised traffic; requests held until granted.
    pf = 1'b0; pl = 1'b0; lw = 1'b0; ld = 32'h0;
    for (int i = 0; i < 600; i++) begin
      if (!pf && $urandom_range(0, 9) < 7) begin
        pf = 1'b1;
        fa = rand_addr();
      end
      if (!pl && $urandom_range(0, 9) < 5) begin
        pl = 1'b1;
        lw = 1'($urandom_range(0, 1));
        la = rand_addr();
        ld = $urandom;
      end
      step(pf, fa, pl, lw, la, ld, fg, lg);
      if (fg) pf = 1'b0;
      if (lg) pl = 1'b0;
    end
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);

    chk("queue_drained", 128'(q.size()), 128'(0));
    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (env_mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image", 128'(diffs), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
